uart_autobaud_ctrl: RTL

Auto-baud controller for the UART receive path. When armed, it measures a 0x55 sync character on the serial input and writes the divisor that the 16x baud tick generator consumes. It owns the generator's `baud_16x_in_cycles` input and holds a default divisor until a valid measurement replaces it. The divisor semantics match the generator: tick period = divisor + 1 clocks.

---
 rtl/uart_autobaud_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: measures a 0x55 sync character and drives the 16x tick divisor.
// Optional macro AUTOBAUD_INTERVAL_CHECK_EN enables per-edge interval consistency checking.
module uart_autobaud_ctrl #(
    parameter logic [7:0]  DEFAULT_DIV = 8'd26,
    parameter logic [7:0]  MIN_DIV     = 8'd4,
    parameter logic [15:0] IDLE_CYCLES = 16'd1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       start,
    output logic [7:0] baud_16x_in_cycles,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       locked
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_WAIT_START,
        S_MEASURE,
        S_CALC,
        S_DONE,
        S_FAIL
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q, rx_prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  fe_q, fe_d;
    logic [15:0] t_q, t_d;
    logic [7:0]  div_q, div_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        locked_q, locked_d;

    logic        falling_edge;
    logic [15:0] cnt_inc;
    logic [15:0] edge_pos;
    logic [16:0] sum17;
    logic [9:0]  q;
    logic [9:0]  q_m1;
    logic        calc_ok;
    logic        interval_bad;

    assign falling_edge = rx_prev_q & ~rx_s_q;
    assign cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign edge_pos     = cnt_q + 16'd1;
    // Divide by 128 with rounding: 8 bit times over 16 ticks per bit.
    assign sum17        = {1'b0, t_q} + 17'd64;
    assign q            = 10'(sum17 >> 7);
    assign q_m1         = q - 10'd1;
    assign calc_ok      = (q != 10'd0) && (q_m1 >= {2'b00, MIN_DIV}) && (q_m1 <= 10'd255);

`ifdef AUTOBAUD_INTERVAL_CHECK_EN
    logic [15:0] i1_q, i1_d;
    logic [15:0] last_q, last_d;
    logic [15:0] ik;
    logic [15:0] ik_diff;

    assign ik           = edge_pos - last_q;
    assign ik_diff      = (ik > i1_q) ? (ik - i1_q) : (i1_q - ik);
    assign interval_bad = (fe_q != 3'd0) && (ik_diff > (i1_q >> 2));

    always_comb begin
        i1_d   = i1_q;
        last_d = last_q;
        if (state_q == S_MEASURE && falling_edge) begin
            last_d = edge_pos;
            if (fe_q == 3'd0) begin
                i1_d = edge_pos;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1_q   <= '0;
            last_q <= '0;
        end else begin
            i1_q   <= i1_d;
            last_q <= last_d;
        end
    end
`else
    assign interval_bad = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fe_d     = fe_q;
        t_d      = t_q;
        div_d    = div_q;
        err_d    = err_q;
        locked_d = locked_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_WAIT_IDLE;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    locked_d = 1'b0;
                end
            end
            S_WAIT_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_CYCLES - 16'd1) begin
                    state_d = S_WAIT_START;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT_START: begin
                if (falling_edge) begin
                    state_d = S_MEASURE;
                    cnt_d   = '0;
                    fe_d    = '0;
                end
            end
            S_MEASURE: begin
                cnt_d = cnt_inc;
                if (falling_edge) begin
                    fe_d = fe_q + 3'd1;
                end
                if (falling_edge && interval_bad) begin
                    state_d = S_FAIL;
                end else if (falling_edge && fe_q == 3'd3) begin
                    state_d = S_CALC;
                    t_d     = edge_pos;
                end else if (cnt_q == 16'hFFFF) begin
                    state_d = S_FAIL;
                end
            end
            S_CALC: begin
                if (calc_ok) begin
                    div_d    = q_m1[7:0];
                    locked_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_FAIL;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_FAIL) begin
            err_d = 1'b1;
        end
        done_d = (state_d == S_DONE) || (state_d == S_FAIL);
        busy_d = (state_d != S_IDLE);
    end

    // Synchroniser resets high so a reset never fakes a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            fe_q      <= '0;
            t_q       <= '0;
            div_q     <= DEFAULT_DIV;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fe_q      <= fe_d;
            t_q       <= t_d;
            div_q     <= div_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
        end
    end

    assign baud_16x_in_cycles = div_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
    assign locked             = locked_q;

endmodule
